// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant, bus lock and ack watchdog.
//
// A master that raises cyc is granted the shared bus one cycle later and keeps it until it drops
// cyc. When both masters request from idle, the one not served last wins. While granted, a
// watchdog counts strobe cycles without acknowledge; on reaching TIMEOUT the granted master sees
// a one-cycle err pulse, the strobe to the slave is suppressed for that cycle and the count
// restarts.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   mN_adr_i/dat_i/sel_i/we_i     master N request (N = 0, 1)
//   mN_cyc_i, mN_stb_i            master N cycle / strobe
//   mN_dat_o, mN_ack_o, mN_err_o  read data, acknowledge, watchdog error to master N
//   s_adr_o/dat_o/sel_o/we_o      shared bus toward the interconnect
//   s_cyc_o, s_stb_o              shared cycle / strobe
//   s_dat_i, s_ack_i              read data and acknowledge from the interconnect
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e     state_q;
  logic       last_q;   // 0: master 0 served last, 1: master 1 served last
  logic [7:0] wdog_q;

  logic gnt0, gnt1, timeout;

  assign gnt0 = (state_q == StGnt0);
  assign gnt1 = (state_q == StGnt1);

  // An ack arriving on the limit cycle wins over the timeout.
  assign timeout = (gnt0 || gnt1) && (wdog_q == TimeoutCnt) && !s_ack_i;

  // Shared bus mux: everything is zero when no master holds the grant.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i && !timeout;
      end
      StGnt1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i && !timeout;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = gnt0 && s_ack_i;
  assign m1_ack_o = gnt1 && s_ack_i;
  assign m0_err_o = gnt0 && timeout;
  assign m1_err_o = gnt1 && timeout;

  // Read data fans out to both masters; blanked only while reset is held.
  assign m0_dat_o = rst_i ? '0 : s_dat_i;
  assign m1_dat_o = rst_i ? '0 : s_dat_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;  // master 0 wins the first simultaneous request
      wdog_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= StGnt0;
            last_q  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q <= StGnt1;
            last_q  <= 1'b1;
          end
        end
        // Bus lock: the grant is held until the owner drops cyc.
        StGnt0: if (!m0_cyc_i) state_q <= StIdle;
        StGnt1: if (!m1_cyc_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // s_stb_o is already low on the timeout cycle, so the count restarts there too.
      if (state_q == StIdle || !s_stb_o || s_ack_i) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [1:0]  m0_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [1:0]  m1_sel_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  wb_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Expected observable event: a new grant on the shared bus, or any ack/err pulse.
  // fl = {m1_err, m0_err, m1_ack, m0_ack}
  typedef struct {
    int          due;
    logic [31:0] adr;
    logic [3:0]  fl;
    logic [31:0] dat;
    logic        stb;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_n  = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int lat, input logic [31:0] adr, input logic [3:0] fl,
                      input logic [31:0] dat, input logic stb);
    exp_t e;
    e.due = cyc_n + lat;
    e.adr = adr;
    e.fl  = fl;
    e.dat = dat;
    e.stb = stb;
    exp_q.push_back(e);
  endtask

  // Monitor: samples mid-cycle and scores every event against the queue.
  logic        prev_cyc = 1'b0;
  logic [31:0] prev_adr = '0;
  always @(negedge clk_i) begin
    logic [3:0] fl;
    exp_t e;
    fl = {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o};
    if (!rst_i && ((s_cyc_o && (!prev_cyc || s_adr_o != prev_adr)) || fl != 4'b0000)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cycle=%0d got adr=%h flags=%b stb=%b want none",
                 cyc_n, s_adr_o, fl, s_stb_o);
      end else begin
        e = exp_q.pop_front();
        if (e.due != cyc_n || e.adr != s_adr_o || e.fl != fl || e.stb != s_stb_o ||
            e.dat != m0_dat_o || e.dat != m1_dat_o) begin
          errors++;
          $display("FAIL event got cycle=%0d adr=%h flags=%b stb=%b dat0=%h dat1=%h want cycle=%0d adr=%h flags=%b stb=%b dat=%h",
                   cyc_n, s_adr_o, fl, s_stb_o, m0_dat_o, m1_dat_o,
                   e.due, e.adr, e.fl, e.stb, e.dat);
        end
      end
    end
    prev_cyc <= s_cyc_o;
    prev_adr <= s_adr_o;
  end

  task automatic check_quiet(input string name);
    checks++;
    if (s_cyc_o || s_stb_o || s_we_o || s_adr_o != 0 || s_dat_o != 0 || s_sel_o != 0 ||
        m0_ack_o || m1_ack_o || m0_err_o || m1_err_o || m0_dat_o != 0 || m1_dat_o != 0) begin
      errors++;
      $display("FAIL %s got cyc=%b stb=%b we=%b adr=%h dat=%h ack=%b%b err=%b%b mdat=%h/%h want all 0",
               name, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m1_ack_o, m0_ack_o,
               m1_err_o, m0_err_o, m0_dat_o, m1_dat_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    m0_adr_i = 32'h100; m0_dat_i = '0; m0_sel_i = 2'b11; m0_we_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 32'h200; m1_dat_i = '0; m1_sel_i = 2'b01; m1_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = 32'h1234_5678; s_ack_i = 1'b0;
    repeat (3) tick();
    check_quiet("reset_outputs");
    s_dat_i = '0;
    rst_i = 1'b0;
    tick();

    // Simultaneous request after reset: master 0 first, then master 1 via idle.
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    push(1, 32'h100, 4'b0000, '0, 1'b0);
    repeat (3) tick();
    m0_cyc_i = 1'b0;
    push(2, 32'h200, 4'b0000, '0, 1'b0);
    repeat (3) tick();
    m1_cyc_i = 1'b0;
    repeat (2) tick();

    // Master 1 read, acked on the third strobe cycle.
    m1_adr_i = 32'h0000_1004; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
    push(1, 32'h0000_1004, 4'b0000, '0, 1'b1);
    repeat (3) tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    push(0, 32'h0000_1004, 4'b0010, 32'hDEAD_BEEF, 1'b1);
    tick();
    s_ack_i = 1'b0; s_dat_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    repeat (2) tick();

    // Bus lock: master 0 holds cyc for 10 cycles while master 1 waits.
    m0_cyc_i = 1'b1;
    push(1, 32'h100, 4'b0000, '0, 1'b0);
    tick();
    m1_adr_i = 32'h200; m1_cyc_i = 1'b1;
    repeat (9) tick();
    m0_cyc_i = 1'b0;
    push(2, 32'h200, 4'b0000, '0, 1'b0);
    repeat (3) tick();
    m1_cyc_i = 1'b0;
    repeat (2) tick();

    // Watchdog: no ack, err on the 5th strobe cycle, then again 5 cycles later.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    push(1, 32'h100, 4'b0000, '0, 1'b1);
    push(5, 32'h100, 4'b0100, '0, 1'b0);
    push(10, 32'h100, 4'b0100, '0, 1'b0);
    repeat (11) tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    repeat (2) tick();

    // Ack on the very cycle the count reaches the limit: ack wins, no err.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_dat_i = 32'hCAFE;
    push(1, 32'h100, 4'b0000, '0, 1'b1);
    repeat (5) tick();
    s_ack_i = 1'b1; s_dat_i = 32'h5A5A_0001;
    push(0, 32'h100, 4'b0001, 32'h5A5A_0001, 1'b1);
    tick();
    s_ack_i = 1'b0; s_dat_i = '0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    repeat (2) tick();

    // Reset during a master 1 write, then simultaneous requests favour master 0.
    m1_adr_i = 32'h300; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_dat_i = 32'h77; s_dat_i = 32'h1111_2222;
    push(1, 32'h300, 4'b0000, 32'h1111_2222, 1'b1);
    tick();
    tick();
    rst_i = 1'b1;
    m0_cyc_i = 1'b1;
    #1;
    check_quiet("reset_mid_write");
    tick();
    tick();
    rst_i = 1'b0;
    push(1, 32'h100, 4'b0000, 32'h1111_2222, 1'b0);
    tick();
    tick();
    m0_cyc_i = 1'b0;
    push(2, 32'h300, 4'b0000, 32'h1111_2222, 1'b1);
    repeat (3) tick();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; s_dat_i = '0;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: slave-ack watchdog limit in cycles, legal range 1..255.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have, for N=0,1, port mN_adr_i  in  32  master N address.
REQ-005 SHALL have, for N=0,1, port mN_dat_i  in  32  master N write data.
REQ-006 SHALL have, for N=0,1, port mN_dat_o  out  32  read data to master N.
REQ-007 SHALL have, for N=0,1, port mN_sel_i  in  2  master N byte select.
REQ-008 SHALL have, for N=0,1, port mN_we_i  in  1  master N write enable.
REQ-009 SHALL have, for N=0,1, port mN_cyc_i  in  1  master N bus request/cycle.
REQ-010 SHALL have, for N=0,1, port mN_stb_i  in  1  master N strobe.
REQ-011 SHALL have, for N=0,1, port mN_ack_o  out  1  transfer acknowledge to master N.
REQ-012 SHALL have, for N=0,1, port mN_err_o  out  1  watchdog timeout error to master N.
REQ-013 SHALL have ports s_adr_o out 32, s_dat_o out 32, s_sel_o out 2, s_we_o out 1, s_cyc_o out 1, s_stb_o out 1: shared bus to the interconnect.
REQ-014 SHALL have ports s_dat_i in 32 and s_ack_i in 1: read data and acknowledge from the interconnect.

Function
REQ-015 SHALL implement states IDLE, GNT0, GNT1, held in a registered state register.
REQ-016 SHALL keep a registered last-served flag `last`: 0 = master 0 served last, 1 = master 1.
REQ-017 In IDLE, with only mN_cyc_i high, SHALL move to GNTN on the next edge.
REQ-018 In IDLE, with both cyc high, SHALL grant the master not equal to `last` (round robin).
REQ-019 On entry to GNTN SHALL set `last`=N.
REQ-020 Grant latency: one cycle from request in IDLE to s_cyc_o high.
REQ-021 In GNTN SHALL drive s_adr/dat/sel/we/stb_o combinationally from master N and s_cyc_o = mN_cyc_i.
REQ-022 In IDLE SHALL drive s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0, s_sel_o=0.
REQ-023 SHALL hold GNTN while mN_cyc_i is high, regardless of the other master's requests (bus lock).
REQ-024 When mN_cyc_i is low in GNTN, SHALL return to IDLE on the next edge; the re-grant decision is made there.
REQ-025 SHALL route s_ack_i only to the granted master's mN_ack_o; ungranted ack_o and err_o are 0.
REQ-026 SHALL drive both m0_dat_o and m1_dat_o from s_dat_i unconditionally.
REQ-027 SHALL keep an 8-bit watchdog counter: increment each cycle s_stb_o=1 and s_ack_i=0; clear on s_ack_i, on s_stb_o=0, and in IDLE.
REQ-028 When the counter equals TIMEOUT with s_ack_i=0, SHALL pulse mN_err_o for exactly one cycle, force s_stb_o=0 that cycle, and clear the counter.
REQ-029 If s_ack_i=1 in the same cycle the counter reaches TIMEOUT, SHALL give ack priority: ack passed, no err.
REQ-030 SHALL ignore s_ack_i in IDLE; no ack_o asserted.

Reset
REQ-031 While rst_i is high SHALL force state=IDLE, last=1, counter=0, asynchronously.
REQ-032 During reset SHALL hold s_cyc_o, s_stb_o, s_we_o, both ack_o and both err_o at 0; all data/address outputs at 0.
REQ-033 Reset mid-transfer SHALL drop s_cyc_o in the same cycle; after release the first grant follows REQ-017/018 with master 0 favoured.

Verification
REQ-034 After reset, m0_cyc_i=m1_cyc_i=1 in the same cycle -> GNT0 next edge, s_adr_o=m0_adr_i; m0 drops cyc -> IDLE, then GNT1.
REQ-035 m1 read, adr 0x00001004, slave acks on 3rd stb cycle with 0xDEADBEEF -> m1_ack_o=1 one cycle, m1_dat_o=0xDEADBEEF, m0_ack_o=0.
REQ-036 m0 holds cyc for 10 cycles while m1 requests -> m1 never granted until m0 cyc low; then GNT1 within 2 cycles.
REQ-037 TIMEOUT=4, m0 strobes to a slave that never acks -> m0_err_o single pulse on 5th stb cycle, s_stb_o=0 that cycle, counter=0.
REQ-038 Assert rst_i mid-GNT1 write -> s_cyc_o=0 immediately; after release, simultaneous requests -> master 0 granted.
